bram_fifo_ctl: RTL and testbench



---
 rtl/bram.sv | 31 +++
 rtl/bram_fifo_ctl.sv | 81 ++++++++
 tb/tb_bram_fifo_ctl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bram.sv
// Dual-ported block RAM: writes commit on the rising edge, reads capture on the
// falling edge, and the read port drives zero whenever it is not enabled.
module bram #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [ADDR_SZ-1:0] i_waddr,
  input  logic [DATA_SZ-1:0] i_wdata,
  input  logic               i_rd_en,
  input  logic [ADDR_SZ-1:0] i_raddr,
  output logic [DATA_SZ-1:0] o_rdata
);

  localparam int MEM_MAX = 1 << ADDR_SZ;

  logic [DATA_SZ-1:0] mem [MEM_MAX];
  logic [DATA_SZ-1:0] rd_q;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_waddr] <= i_wdata;
  end

  always_ff @(negedge i_clk) begin
    if (i_rd_en) rd_q <= mem[i_raddr];
  end

  assign o_rdata = i_rd_en ? rd_q : '0;

endmodule

// File: rtl/bram_fifo_ctl.sv
// FIFO controller driving both ports of a bram, with a one-word output register
// in front of the read stream; capacity is MEM_MAX+1 words.
module bram_fifo_ctl #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr_valid,
  output logic               o_wr_ready,
  input  logic [DATA_SZ-1:0] i_wr_data,
  output logic               o_rd_valid,
  input  logic               i_rd_ready,
  output logic [DATA_SZ-1:0] o_rd_data,
  output logic [ADDR_SZ:0]   o_count,
  output logic               o_mem_wr_en,
  output logic [ADDR_SZ-1:0] o_mem_waddr,
  output logic [DATA_SZ-1:0] o_mem_wdata,
  output logic               o_mem_rd_en,
  output logic [ADDR_SZ-1:0] o_mem_raddr,
  input  logic [DATA_SZ-1:0] i_mem_rdata
);

  localparam int               MEM_MAX   = 1 << ADDR_SZ;
  localparam logic [ADDR_SZ:0] MCNT_FULL = (ADDR_SZ+1)'(MEM_MAX);

  logic [ADDR_SZ-1:0] wptr;
  logic [ADDR_SZ-1:0] rptr;
  logic [ADDR_SZ:0]   mcnt;
  logic               out_valid;
  logic [DATA_SZ-1:0] out_data;

  logic wr_xfer;
  logic fetch;
  logic pop;

  // Ready depends only on registered state so upstream never sees a path from i_rd_ready.
  always_comb begin
    o_wr_ready = i_rst_n & (mcnt != MCNT_FULL);
    wr_xfer    = i_wr_valid & o_wr_ready;
    fetch      = (mcnt != '0) & (~out_valid | i_rd_ready);
    pop        = out_valid & i_rd_ready;
  end

  assign o_mem_wr_en = wr_xfer;
  assign o_mem_waddr = wptr;
  assign o_mem_wdata = i_wr_data;
  assign o_mem_rd_en = fetch;
  assign o_mem_raddr = rptr;

  assign o_rd_valid = out_valid;
  assign o_rd_data  = out_data;
  assign o_count    = mcnt + {{ADDR_SZ{1'b0}}, out_valid};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      mcnt      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wr_xfer) wptr <= wptr + ADDR_SZ'(1);
      if (fetch)   rptr <= rptr + ADDR_SZ'(1);

      case ({wr_xfer, fetch})
        2'b10:   mcnt <= mcnt + (ADDR_SZ+1)'(1);
        2'b01:   mcnt <= mcnt - (ADDR_SZ+1)'(1);
        default: mcnt <= mcnt;
      endcase

      if (fetch) begin
        out_data  <= i_mem_rdata;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctl.sv
// Bench for bram_fifo_ctl wired to a bram: queue-based model checked every
// cycle, plus directed literal expectations for the key scenarios.
module tb_bram_fifo_ctl;

  localparam int DW      = 16;
  localparam int AW      = 8;
  localparam int MEM_MAX = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wv = 1'b0;
  logic          rr = 1'b0;
  logic [DW-1:0] wd = '0;

  logic          wr_ready, rd_valid, mem_wr_en, mem_rd_en;
  logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
  logic [AW:0]   count;
  logic [AW-1:0] mem_waddr, mem_raddr;

  always #10 clk = ~clk;

  bram_fifo_ctl #(.DATA_SZ(DW), .ADDR_SZ(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_valid(wv), .o_wr_ready(wr_ready), .i_wr_data(wd),
    .o_rd_valid(rd_valid), .i_rd_ready(rr), .o_rd_data(rd_data),
    .o_count(count),
    .o_mem_wr_en(mem_wr_en), .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata),
    .o_mem_rd_en(mem_rd_en), .o_mem_raddr(mem_raddr), .i_mem_rdata(mem_rdata)
  );

  bram #(.DATA_SZ(DW), .ADDR_SZ(AW)) u_mem (
    .i_clk(clk), .i_wr_en(mem_wr_en), .i_waddr(mem_waddr), .i_wdata(mem_wdata),
    .i_rd_en(mem_rd_en), .i_raddr(mem_raddr), .o_rdata(mem_rdata)
  );

  int errors = 0;
  int checks = 0;

  // Model: words resident in the bram, the output register, and all words in flight.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic          ov;
  logic [DW-1:0] od;
  int unsigned   wcnt, rcnt, n_popped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_wr_ready();
    return mq.size() != MEM_MAX;
  endfunction

  function automatic bit m_fetch();
    return (mq.size() != 0) && (!ov || rr);
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    ov   = 1'b0;
    od   = '0;
    wcnt = 0;
    rcnt = 0;
  endtask

  task automatic model_update();
    bit wx, fx, px;
    if (!rst_n) return;
    wx = wv && m_wr_ready();
    fx = m_fetch();
    px = ov && rr;
    if (px) begin
      void'(exp_q.pop_front());
      n_popped++;
    end
    if (fx) begin
      od = mq.pop_front();
      ov = 1'b1;
      rcnt++;
    end else if (px) begin
      ov = 1'b0;
    end
    if (wx) begin
      mq.push_back(wd);
      exp_q.push_back(wd);
      wcnt++;
    end
  endtask

  task automatic compare();
    if (!rst_n) begin
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_count", count, 0);
      chk("rst_mem_wr_en", mem_wr_en, 0);
      chk("rst_mem_rd_en", mem_rd_en, 0);
    end else begin
      chk("wr_ready", wr_ready, m_wr_ready());
      chk("rd_valid", rd_valid, ov);
      if (ov) chk("rd_data", rd_data, od);
      if (ov && exp_q.size() != 0) chk("order", rd_data, exp_q[0]);
      chk("count", count, mq.size() + ov);
      chk("mem_wr_en", mem_wr_en, wv && m_wr_ready());
      if (wv && m_wr_ready()) begin
        chk("mem_waddr", mem_waddr, wcnt % MEM_MAX);
        chk("mem_wdata", mem_wdata, wd);
      end
      chk("mem_rd_en", mem_rd_en, m_fetch());
      if (m_fetch()) chk("mem_raddr", mem_raddr, rcnt % MEM_MAX);
    end
  endtask

  // Inputs are set just after a posedge; outputs are compared on the negedge.
  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  idx, p0, sent, cyc;
    bit  acc;
    n_popped = 0;
    model_reset();

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    chk("reset_count", count, 0);
    rst_n = 1'b1;

    // Single word
    wv = 1'b1; wd = 16'hA5A5; rr = 1'b0;
    cycle();
    wv = 1'b0;
    cycle();
    chk("single_valid", rd_valid, 1);
    chk("single_data", rd_data, 16'hA5A5);
    chk("single_count", count, 1);
    rr = 1'b1;
    cycle();
    chk("single_pop_valid", rd_valid, 0);
    chk("single_pop_count", count, 0);
    rr = 1'b0;

    // Fill with no reader
    idx = 0;
    for (int c = 0; c < 301; c++) begin
      wv  = 1'b1;
      wd  = DW'(idx);
      acc = m_wr_ready();
      cycle();
      if (acc) idx++;
    end
    chk("fill_accepted", idx, 257);
    chk("fill_count", count, 257);
    chk("fill_wr_ready", wr_ready, 0);

    // Full boundary: pop and write together; write refused this cycle
    wv = 1'b1; wd = 16'd257; rr = 1'b1;
    chk("full_wr_ready", wr_ready, 0);
    cycle();
    chk("full_pop_count", count, 256);
    rr = 1'b0;
    cycle();
    wv = 1'b0;
    chk("full_refill_count", count, 257);

    // Drain
    p0 = int'(n_popped);
    rr = 1'b1;
    for (int c = 0; c < 270; c++) cycle();
    chk("drain_popped", n_popped - p0, 257);
    chk("drain_valid", rd_valid, 0);
    chk("drain_count", count, 0);
    rr = 1'b0;

    // Random streaming, 1000 words
    p0 = int'(n_popped);
    sent = 0;
    cyc = 0;
    while ((int'(n_popped) - p0) < 1000 && cyc < 10000) begin
      wv  = (sent < 1000) && ($urandom_range(0, 1) == 1);
      wd  = DW'($urandom);
      rr  = ($urandom_range(0, 1) == 1);
      acc = wv && m_wr_ready();
      cycle();
      if (acc) sent++;
      cyc++;
    end
    chk("stream_popped", n_popped - p0, 1000);
    chk("stream_wrapped", wcnt >= 2 * MEM_MAX, 1);
    wv = 1'b0; rr = 1'b0;
    cycle();

    // Async reset mid-stream
    cyc = 0;
    while (mq.size() + ov < 10 && cyc < 40) begin
      wv = 1'b1;
      wd = DW'($urandom);
      cycle();
      cyc++;
    end
    wv = 1'b0;
    chk("pre_rst_count", count, 10);
    #1 rst_n = 1'b0;
    #1;
    chk("async_wr_ready", wr_ready, 0);
    chk("async_rd_valid", rd_valid, 0);
    chk("async_rd_data", rd_data, 0);
    chk("async_count", count, 0);
    chk("async_mem_wr_en", mem_wr_en, 0);
    chk("async_mem_rd_en", mem_rd_en, 0);
    #1 rst_n = 1'b1;
    model_reset();
    wv = 1'b1; wd = 16'h1234; rr = 1'b0;
    #1;
    chk("post_rst_waddr", mem_waddr, 0);
    chk("post_rst_wr_en", mem_wr_en, 1);
    cycle();
    wv = 1'b0;
    cycle();
    chk("post_rst_valid", rd_valid, 1);
    chk("post_rst_data", rd_data, 16'h1234);
    rr = 1'b1;
    cycle();
    chk("post_rst_pop_count", count, 0);
    rr = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
